id_ex_stage: RTL and testbench
==============================

ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: clk input 1 (rising-edge clock); reset input 1 (asynchronous, active-low; 0 = reset).
REQ-002 Decode-side inputs SHALL be: d_rs_data in 32; d_rt_data in 32; d_imm32 in 32 (already extended); d_alu_op in 3; d_alusrc in 1 (1 = B from imm); d_rs_addr in 5; d_rt_addr in 5; d_waddr in 5; d_regwrite in 1; d_valid in 1.
REQ-003 Control inputs SHALL be: e_hold in 1 (freeze E stage); e_flush in 1 (load bubble).
REQ-004 Forwarding inputs SHALL be: m_regwrite in 1; m_waddr in 5; m_wdata in 32 (MEM stage); w_regwrite in 1; w_waddr in 5; w_wdata in 32 (WB stage).
REQ-005 Outputs SHALL be: A out 32; B out 32; ALUOp out 3 (to the ALU); e_rt_data out 32 (store data); e_waddr out 5; e_regwrite out 1; e_valid out 1.

Function
REQ-006 Stage register contents SHALL be: valid, alu_op, alusrc, rs_addr, rt_addr, waddr, regwrite, rs_q, rt_q, imm_q.
REQ-007 On a rising edge with e_hold=0 and e_flush=0, the register SHALL load all d_* inputs (one-cycle latency, D to E).
REQ-008 On a rising edge with e_hold=0 and e_flush=1, the register SHALL load a bubble: valid=0, regwrite=0, waddr=0, alu_op=3'b000, all data fields 0.
REQ-009 e_hold SHALL take priority over e_flush; a flush coinciding with hold is ignored, and the controller keeps e_flush asserted until a non-hold cycle.
REQ-010 On a rising edge with e_hold=1, all control fields SHALL hold; rs_q and rt_q SHALL reload with their currently forwarded values (REQ-012), so a WB value retiring during a hold is not lost.
REQ-011 A match for operand source X SHALL require stage regwrite=1, stage waddr==X, and X!=0; register 0 SHALL never be forwarded.
REQ-012 Forwarded rs value (fA) SHALL be: m_wdata on MEM match, else w_wdata on WB match, else rs_q; forwarded rt value (fT) is the same with rt_addr and rt_q; MEM SHALL win over WB.
REQ-013 A SHALL equal fA; B SHALL equal imm_q when alusrc=1, else fT; e_rt_data SHALL always equal fT; ALUOp SHALL equal the registered alu_op.
REQ-014 Forwarding muxes SHALL be purely combinational, with no added cycle between the stage register and the ALU.
REQ-015 e_regwrite SHALL equal regwrite AND valid; e_valid and e_waddr SHALL be the registered values.
REQ-016 alu_op values 3'b110 and 3'b111 SHALL be passed through unchanged; decode never issues them.
REQ-017 With d_valid=0 and no flush, the stage SHALL load the inputs but present e_regwrite=0.

Reset
REQ-018 While reset=0, the register SHALL immediately, asynchronously hold a bubble (REQ-008 values); outputs SHALL be A=0, B=0, ALUOp=0, e_rt_data=0, e_waddr=0, e_regwrite=0, e_valid=0, unless a MEM/WB match forwards data.
REQ-019 The first load after reset release SHALL occur on the first rising edge with reset=1 and e_hold=0.
REQ-020 Reset asserted mid-hold SHALL discard the held instruction.

Structure
REQ-021 A shared package SHALL hold: ALUOp constants (ADD=000, SUB=001, AND=010, OR=011, SRL=100, SRA=101), REG_ZERO=5'd0, and the forward-select encoding (REG=0, WB=1, MEM=2).
REQ-022 One sub-module fwd_mux SHALL be instantiated twice (rs, rt); it takes addr, reg value and MEM/WB ports, and outputs the selected value.

Verification
REQ-023 Load: d_rs_data=5, d_imm32=7, d_alusrc=1, d_alu_op=ADD, no hazards -> next cycle A=5, B=7, ALUOp=000, e_valid=1.
REQ-024 Priority: rs_addr=8, m_waddr=8 with m_wdata=0xAAAA, w_waddr=8 with w_wdata=0xBBBB, both regwrite=1 -> A=0xAAAA; drop m_regwrite -> A=0xBBBB.
REQ-025 Zero register: rt_addr=0, m_waddr=0, m_regwrite=1, m_wdata=0x1234, alusrc=0 -> B=rt_q=0.
REQ-026 Hold refresh: e_hold=1 for 2 cycles; in cycle 1, WB writes rs=0x55 then retires -> A=0x55 in cycle 2 and after release.
REQ-027 Flush vs hold: e_flush=1 with e_hold=1 -> contents unchanged; then e_hold=0 with e_flush=1 -> e_valid=0, e_regwrite=0, ALUOp=000.
REQ-028 Async reset: valid instruction loaded, reset=0 between clock edges -> e_valid=0 and e_regwrite=0 without waiting for a clock edge.

Source files
------------

// File: rtl/id_ex_stage_pkg.sv
// -----------------------------------------------------------------------------
// id_ex_stage_pkg
// Shared constants and types for the ID/EX pipeline stage:
//   - ALU operation encodings presented on ALUOp
//   - REG_ZERO, the architectural zero register (never forwarded)
//   - fwd_sel_e, the operand source chosen by the forwarding muxes
// -----------------------------------------------------------------------------
package id_ex_stage_pkg;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned RADDR_W  = 5;
    localparam int unsigned ALU_OP_W = 3;

    localparam logic [ALU_OP_W-1:0] ALU_ADD = 3'b000;
    localparam logic [ALU_OP_W-1:0] ALU_SUB = 3'b001;
    localparam logic [ALU_OP_W-1:0] ALU_AND = 3'b010;
    localparam logic [ALU_OP_W-1:0] ALU_OR  = 3'b011;
    localparam logic [ALU_OP_W-1:0] ALU_SRL = 3'b100;
    localparam logic [ALU_OP_W-1:0] ALU_SRA = 3'b101;

    localparam logic [RADDR_W-1:0] REG_ZERO = 5'd0;

    typedef enum logic [1:0] {
        FWD_REG = 2'd0,
        FWD_WB  = 2'd1,
        FWD_MEM = 2'd2
    } fwd_sel_e;

endpackage

// File: rtl/id_ex_stage_if.sv
// -----------------------------------------------------------------------------
// id_ex_stage_if
// Bundles every non-clock/reset signal of the ID/EX stage.
//   master : decode + hazard controller + MEM/WB forwarding sources (tb side)
//   slave  : the id_ex_stage itself
// Decode side : d_rs_data, d_rt_data, d_imm32, d_alu_op, d_alusrc, d_rs_addr,
//               d_rt_addr, d_waddr, d_regwrite, d_valid
// Control     : e_hold, e_flush
// Forwarding  : m_regwrite/m_waddr/m_wdata, w_regwrite/w_waddr/w_wdata
// Execute side: A, B, ALUOp, e_rt_data, e_waddr, e_regwrite, e_valid
// Debug       : dbg_fwd_a_sel, dbg_fwd_t_sel (live forwarding source selects)
//
// Stage control semantics: there is no valid/ready handshake. Each rising edge
// the stage either loads the decode inputs (e_hold=0, e_flush=0), loads a
// bubble (e_hold=0, e_flush=1) or freezes its control fields (e_hold=1, flush
// ignored). d_valid only qualifies the instruction; it never stalls the stage.
// -----------------------------------------------------------------------------
interface id_ex_stage_if;

    logic [31:0] d_rs_data;
    logic [31:0] d_rt_data;
    logic [31:0] d_imm32;
    logic [2:0]  d_alu_op;
    logic        d_alusrc;
    logic [4:0]  d_rs_addr;
    logic [4:0]  d_rt_addr;
    logic [4:0]  d_waddr;
    logic        d_regwrite;
    logic        d_valid;

    logic        e_hold;
    logic        e_flush;

    logic        m_regwrite;
    logic [4:0]  m_waddr;
    logic [31:0] m_wdata;
    logic        w_regwrite;
    logic [4:0]  w_waddr;
    logic [31:0] w_wdata;

    logic [31:0] A;
    logic [31:0] B;
    logic [2:0]  ALUOp;
    logic [31:0] e_rt_data;
    logic [4:0]  e_waddr;
    logic        e_regwrite;
    logic        e_valid;

    id_ex_stage_pkg::fwd_sel_e dbg_fwd_a_sel;
    id_ex_stage_pkg::fwd_sel_e dbg_fwd_t_sel;

    modport master (
        output d_rs_data, d_rt_data, d_imm32, d_alu_op, d_alusrc,
               d_rs_addr, d_rt_addr, d_waddr, d_regwrite, d_valid,
               e_hold, e_flush,
               m_regwrite, m_waddr, m_wdata, w_regwrite, w_waddr, w_wdata,
        input  A, B, ALUOp, e_rt_data, e_waddr, e_regwrite, e_valid,
               dbg_fwd_a_sel, dbg_fwd_t_sel
    );

    modport slave (
        input  d_rs_data, d_rt_data, d_imm32, d_alu_op, d_alusrc,
               d_rs_addr, d_rt_addr, d_waddr, d_regwrite, d_valid,
               e_hold, e_flush,
               m_regwrite, m_waddr, m_wdata, w_regwrite, w_waddr, w_wdata,
        output A, B, ALUOp, e_rt_data, e_waddr, e_regwrite, e_valid,
               dbg_fwd_a_sel, dbg_fwd_t_sel
    );

endinterface

// File: rtl/id_ex_stage_fwd_mux.sv
// -----------------------------------------------------------------------------
// fwd_mux
// Purely combinational operand forwarding for one source register.
//   addr       : source register number held in the E stage
//   reg_val    : value captured in the E stage register
//   m_*        : MEM stage write port (highest priority, youngest result)
//   w_*        : WB stage write port
//   fwd_val    : selected operand value
//   sel        : which source was selected (debug visibility)
// Register 0 is never forwarded, even if a later stage claims to write it.
// -----------------------------------------------------------------------------
module fwd_mux
    import id_ex_stage_pkg::*;
(
    input  logic [4:0]  addr,
    input  logic [31:0] reg_val,
    input  logic        m_regwrite,
    input  logic [4:0]  m_waddr,
    input  logic [31:0] m_wdata,
    input  logic        w_regwrite,
    input  logic [4:0]  w_waddr,
    input  logic [31:0] w_wdata,
    output logic [31:0] fwd_val,
    output fwd_sel_e    sel
);

    logic m_hit;
    logic w_hit;

    assign m_hit = m_regwrite && (m_waddr == addr) && (addr != REG_ZERO);
    assign w_hit = w_regwrite && (w_waddr == addr) && (addr != REG_ZERO);

    // MEM holds the younger result, so it shadows a WB write to the same reg.
    always_comb begin
        sel     = FWD_REG;
        fwd_val = reg_val;
        if (m_hit) begin
            sel     = FWD_MEM;
            fwd_val = m_wdata;
        end else if (w_hit) begin
            sel     = FWD_WB;
            fwd_val = w_wdata;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// -----------------------------------------------------------------------------
// id_ex_stage
// ID->EX pipeline register with combinational operand forwarding into the ALU.
// Ports:
//   clk    : rising-edge clock
//   reset  : asynchronous, active-low; forces a bubble into the stage
//   bus    : id_ex_stage_if.slave (decode inputs, hold/flush, MEM/WB
//            forwarding sources, ALU-facing outputs, forward-select debug)
// Behaviour per edge: hold freezes control fields but refreshes rs_q/rt_q with
// their forwarded values; otherwise flush loads a bubble, else decode loads.
// -----------------------------------------------------------------------------
module id_ex_stage
    import id_ex_stage_pkg::*;
(
    input logic         clk,
    input logic         reset,
    id_ex_stage_if.slave bus
);

    logic        valid_q,    valid_d;
    logic [2:0]  alu_op_q,   alu_op_d;
    logic        alusrc_q,   alusrc_d;
    logic [4:0]  rs_addr_q,  rs_addr_d;
    logic [4:0]  rt_addr_q,  rt_addr_d;
    logic [4:0]  waddr_q,    waddr_d;
    logic        regwrite_q, regwrite_d;
    logic [31:0] rs_q,       rs_d;
    logic [31:0] rt_q,       rt_d;
    logic [31:0] imm_q,      imm_d;

    logic [31:0] fwd_a;
    logic [31:0] fwd_t;

    fwd_mux u_fwd_rs (
        .addr       (rs_addr_q),
        .reg_val    (rs_q),
        .m_regwrite (bus.m_regwrite),
        .m_waddr    (bus.m_waddr),
        .m_wdata    (bus.m_wdata),
        .w_regwrite (bus.w_regwrite),
        .w_waddr    (bus.w_waddr),
        .w_wdata    (bus.w_wdata),
        .fwd_val    (fwd_a),
        .sel        (bus.dbg_fwd_a_sel)
    );

    fwd_mux u_fwd_rt (
        .addr       (rt_addr_q),
        .reg_val    (rt_q),
        .m_regwrite (bus.m_regwrite),
        .m_waddr    (bus.m_waddr),
        .m_wdata    (bus.m_wdata),
        .w_regwrite (bus.w_regwrite),
        .w_waddr    (bus.w_waddr),
        .w_wdata    (bus.w_wdata),
        .fwd_val    (fwd_t),
        .sel        (bus.dbg_fwd_t_sel)
    );

    always_comb begin
        valid_d    = valid_q;
        alu_op_d   = alu_op_q;
        alusrc_d   = alusrc_q;
        rs_addr_d  = rs_addr_q;
        rt_addr_d  = rt_addr_q;
        waddr_d    = waddr_q;
        regwrite_d = regwrite_q;
        rs_d       = rs_q;
        rt_d       = rt_q;
        imm_d      = imm_q;

        if (bus.e_hold) begin
            // A WB result retiring while we are frozen would otherwise vanish
            // before the instruction leaves the stage, so capture it now.
            rs_d = fwd_a;
            rt_d = fwd_t;
        end else if (bus.e_flush) begin
            valid_d    = 1'b0;
            alu_op_d   = ALU_ADD;
            alusrc_d   = 1'b0;
            rs_addr_d  = REG_ZERO;
            rt_addr_d  = REG_ZERO;
            waddr_d    = REG_ZERO;
            regwrite_d = 1'b0;
            rs_d       = '0;
            rt_d       = '0;
            imm_d      = '0;
        end else begin
            valid_d    = bus.d_valid;
            alu_op_d   = bus.d_alu_op;
            alusrc_d   = bus.d_alusrc;
            rs_addr_d  = bus.d_rs_addr;
            rt_addr_d  = bus.d_rt_addr;
            waddr_d    = bus.d_waddr;
            regwrite_d = bus.d_regwrite;
            rs_d       = bus.d_rs_data;
            rt_d       = bus.d_rt_data;
            imm_d      = bus.d_imm32;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q    <= 1'b0;
            alu_op_q   <= ALU_ADD;
            alusrc_q   <= 1'b0;
            rs_addr_q  <= REG_ZERO;
            rt_addr_q  <= REG_ZERO;
            waddr_q    <= REG_ZERO;
            regwrite_q <= 1'b0;
            rs_q       <= '0;
            rt_q       <= '0;
            imm_q      <= '0;
        end else begin
            valid_q    <= valid_d;
            alu_op_q   <= alu_op_d;
            alusrc_q   <= alusrc_d;
            rs_addr_q  <= rs_addr_d;
            rt_addr_q  <= rt_addr_d;
            waddr_q    <= waddr_d;
            regwrite_q <= regwrite_d;
            rs_q       <= rs_d;
            rt_q       <= rt_d;
            imm_q      <= imm_d;
        end
    end

    assign bus.A          = fwd_a;
    assign bus.B          = alusrc_q ? imm_q : fwd_t;
    assign bus.e_rt_data  = fwd_t;
    assign bus.ALUOp      = alu_op_q;
    assign bus.e_waddr    = waddr_q;
    assign bus.e_valid    = valid_q;
    // An instruction with d_valid=0 still travels through, but must not write.
    assign bus.e_regwrite = regwrite_q & valid_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// -----------------------------------------------------------------------------
// tb_id_ex_stage
// Directed bench for id_ex_stage: each task drives one scenario and checks the
// outputs against hand-computed values.
// -----------------------------------------------------------------------------
module tb_id_ex_stage;
    import id_ex_stage_pkg::*;

    logic clk;
    logic reset;
    int   pass_cnt;
    int   total_cnt;

    id_ex_stage_if bus ();

    id_ex_stage dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // ---------------- clock / watchdog ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.d_rs_data  = '0;
        bus.d_rt_data  = '0;
        bus.d_imm32    = '0;
        bus.d_alu_op   = ALU_ADD;
        bus.d_alusrc   = 1'b0;
        bus.d_rs_addr  = '0;
        bus.d_rt_addr  = '0;
        bus.d_waddr    = '0;
        bus.d_regwrite = 1'b0;
        bus.d_valid    = 1'b0;
        bus.e_hold     = 1'b0;
        bus.e_flush    = 1'b0;
        bus.m_regwrite = 1'b0;
        bus.m_waddr    = '0;
        bus.m_wdata    = '0;
        bus.w_regwrite = 1'b0;
        bus.w_waddr    = '0;
        bus.w_wdata    = '0;
    endtask

    task automatic drive_instr(input logic [31:0] rs_data, input logic [31:0] rt_data,
                               input logic [31:0] imm, input logic [2:0] op,
                               input logic alusrc, input logic [4:0] rs_addr,
                               input logic [4:0] rt_addr, input logic [4:0] waddr,
                               input logic regwrite, input logic valid);
        bus.d_rs_data  = rs_data;
        bus.d_rt_data  = rt_data;
        bus.d_imm32    = imm;
        bus.d_alu_op   = op;
        bus.d_alusrc   = alusrc;
        bus.d_rs_addr  = rs_addr;
        bus.d_rt_addr  = rt_addr;
        bus.d_waddr    = waddr;
        bus.d_regwrite = regwrite;
        bus.d_valid    = valid;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1'b0;
        clear_inputs();
        drive_instr(32'h1111, 32'h2222, 32'h3333, ALU_OR, 1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1);
        step();
        step();
        total_cnt++; if (bus.A !== 32'h0) $display("FAIL reset_a: got %h expected %h", bus.A, 32'h0); else pass_cnt++;
        total_cnt++; if (bus.B !== 32'h0) $display("FAIL reset_b: got %h expected %h", bus.B, 32'h0); else pass_cnt++;
        total_cnt++; if (bus.ALUOp !== 3'b000) $display("FAIL reset_aluop: got %b expected %b", bus.ALUOp, 3'b000); else pass_cnt++;
        total_cnt++; if (bus.e_rt_data !== 32'h0) $display("FAIL reset_rt_data: got %h expected %h", bus.e_rt_data, 32'h0); else pass_cnt++;
        total_cnt++; if (bus.e_waddr !== 5'd0) $display("FAIL reset_waddr: got %h expected %h", bus.e_waddr, 5'd0); else pass_cnt++;
        total_cnt++; if (bus.e_regwrite !== 1'b0) $display("FAIL reset_regwrite: got %b expected 0", bus.e_regwrite); else pass_cnt++;
        total_cnt++; if (bus.e_valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", bus.e_valid); else pass_cnt++;
        // Release away from the edge; the very next edge performs the first load.
        #2 reset = 1'b1;
        step();
        total_cnt++; if (bus.e_valid !== 1'b1) $display("FAIL first_load_valid: got %b expected 1", bus.e_valid); else pass_cnt++;
        total_cnt++; if (bus.ALUOp !== ALU_OR) $display("FAIL first_load_aluop: got %b expected %b", bus.ALUOp, ALU_OR); else pass_cnt++;
    endtask

    task automatic test_load();
        clear_inputs();
        drive_instr(32'd5, 32'd9, 32'd7, ALU_ADD, 1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1);
        step();
        total_cnt++; if (bus.A !== 32'd5) $display("FAIL load_a: got %h expected %h", bus.A, 32'd5); else pass_cnt++;
        total_cnt++; if (bus.B !== 32'd7) $display("FAIL load_b_imm: got %h expected %h", bus.B, 32'd7); else pass_cnt++;
        total_cnt++; if (bus.ALUOp !== 3'b000) $display("FAIL load_aluop: got %b expected %b", bus.ALUOp, 3'b000); else pass_cnt++;
        total_cnt++; if (bus.e_valid !== 1'b1) $display("FAIL load_valid: got %b expected 1", bus.e_valid); else pass_cnt++;
        total_cnt++; if (bus.e_regwrite !== 1'b1) $display("FAIL load_regwrite: got %b expected 1", bus.e_regwrite); else pass_cnt++;
        total_cnt++; if (bus.e_waddr !== 5'd3) $display("FAIL load_waddr: got %h expected %h", bus.e_waddr, 5'd3); else pass_cnt++;
        total_cnt++; if (bus.e_rt_data !== 32'd9) $display("FAIL load_rt_data: got %h expected %h", bus.e_rt_data, 32'd9); else pass_cnt++;
        // Back-to-back: register operand path for B.
        drive_instr(32'h40, 32'h20, 32'hFFFF, ALU_SUB, 1'b0, 5'd4, 5'd5, 5'd6, 1'b1, 1'b1);
        step();
        total_cnt++; if (bus.B !== 32'h20) $display("FAIL load_b_reg: got %h expected %h", bus.B, 32'h20); else pass_cnt++;
        total_cnt++; if (bus.ALUOp !== ALU_SUB) $display("FAIL load2_aluop: got %b expected %b", bus.ALUOp, ALU_SUB); else pass_cnt++;
        total_cnt++; if (bus.A !== 32'h40) $display("FAIL load2_a: got %h expected %h", bus.A, 32'h40); else pass_cnt++;
    endtask

    task automatic test_priority();
        clear_inputs();
        drive_instr(32'h1, 32'h2, 32'h0, ALU_ADD, 1'b0, 5'd8, 5'd9, 5'd10, 1'b1, 1'b1);
        step();
        bus.m_regwrite = 1'b1; bus.m_waddr = 5'd8; bus.m_wdata = 32'hAAAA;
        bus.w_regwrite = 1'b1; bus.w_waddr = 5'd8; bus.w_wdata = 32'hBBBB;
        #1;
        total_cnt++; if (bus.A !== 32'hAAAA) $display("FAIL prio_mem: got %h expected %h", bus.A, 32'hAAAA); else pass_cnt++;
        total_cnt++; if (bus.dbg_fwd_a_sel !== FWD_MEM) $display("FAIL prio_sel_mem: got %0d expected %0d", bus.dbg_fwd_a_sel, FWD_MEM); else pass_cnt++;
        total_cnt++; if (bus.B !== 32'h2) $display("FAIL prio_rt_untouched: got %h expected %h", bus.B, 32'h2); else pass_cnt++;
        bus.m_regwrite = 1'b0;
        #1;
        total_cnt++; if (bus.A !== 32'hBBBB) $display("FAIL prio_wb: got %h expected %h", bus.A, 32'hBBBB); else pass_cnt++;
        total_cnt++; if (bus.dbg_fwd_a_sel !== FWD_WB) $display("FAIL prio_sel_wb: got %0d expected %0d", bus.dbg_fwd_a_sel, FWD_WB); else pass_cnt++;
        bus.w_waddr = 5'd9;
        #1;
        total_cnt++; if (bus.A !== 32'h1) $display("FAIL prio_none_a: got %h expected %h", bus.A, 32'h1); else pass_cnt++;
        total_cnt++; if (bus.B !== 32'hBBBB) $display("FAIL prio_wb_rt: got %h expected %h", bus.B, 32'hBBBB); else pass_cnt++;
        total_cnt++; if (bus.e_rt_data !== 32'hBBBB) $display("FAIL prio_wb_store: got %h expected %h", bus.e_rt_data, 32'hBBBB); else pass_cnt++;
        clear_inputs();
        #1;
    endtask

    task automatic test_zero_reg();
        clear_inputs();
        drive_instr(32'h77, 32'h0, 32'h0, ALU_AND, 1'b0, 5'd0, 5'd0, 5'd1, 1'b1, 1'b1);
        step();
        bus.m_regwrite = 1'b1; bus.m_waddr = 5'd0; bus.m_wdata = 32'h1234;
        bus.w_regwrite = 1'b1; bus.w_waddr = 5'd0; bus.w_wdata = 32'h5678;
        #1;
        total_cnt++; if (bus.B !== 32'h0) $display("FAIL zero_b: got %h expected %h", bus.B, 32'h0); else pass_cnt++;
        total_cnt++; if (bus.e_rt_data !== 32'h0) $display("FAIL zero_store: got %h expected %h", bus.e_rt_data, 32'h0); else pass_cnt++;
        total_cnt++; if (bus.A !== 32'h77) $display("FAIL zero_a: got %h expected %h", bus.A, 32'h77); else pass_cnt++;
        clear_inputs();
        #1;
    endtask

    task automatic test_hold_refresh();
        clear_inputs();
        drive_instr(32'h11, 32'h22, 32'h0, ALU_OR, 1'b0, 5'd4, 5'd5, 5'd6, 1'b1, 1'b1);
        step();
        // Decode moves on to something else while E is frozen.
        drive_instr(32'h99, 32'h88, 32'h0, ALU_AND, 1'b0, 5'd7, 5'd7, 5'd12, 1'b1, 1'b0);
        bus.e_hold = 1'b1;
        bus.w_regwrite = 1'b1; bus.w_waddr = 5'd4; bus.w_wdata = 32'h55;
        #1;
        total_cnt++; if (bus.A !== 32'h55) $display("FAIL hold_c1_a: got %h expected %h", bus.A, 32'h55); else pass_cnt++;
        step();
        bus.w_regwrite = 1'b0;
        #1;
        total_cnt++; if (bus.A !== 32'h55) $display("FAIL hold_c2_a: got %h expected %h", bus.A, 32'h55); else pass_cnt++;
        total_cnt++; if (bus.ALUOp !== ALU_OR) $display("FAIL hold_aluop: got %b expected %b", bus.ALUOp, ALU_OR); else pass_cnt++;
        total_cnt++; if (bus.e_waddr !== 5'd6) $display("FAIL hold_waddr: got %h expected %h", bus.e_waddr, 5'd6); else pass_cnt++;
        step();
        total_cnt++; if (bus.A !== 32'h55) $display("FAIL hold_end_a: got %h expected %h", bus.A, 32'h55); else pass_cnt++;
        total_cnt++; if (bus.B !== 32'h22) $display("FAIL hold_end_b: got %h expected %h", bus.B, 32'h22); else pass_cnt++;
        // Release: the pending decode (d_valid=0) loads but must not write.
        bus.e_hold = 1'b0;
        step();
        total_cnt++; if (bus.ALUOp !== ALU_AND) $display("FAIL release_aluop: got %b expected %b", bus.ALUOp, ALU_AND); else pass_cnt++;
        total_cnt++; if (bus.e_valid !== 1'b0) $display("FAIL invalid_valid: got %b expected 0", bus.e_valid); else pass_cnt++;
        total_cnt++; if (bus.e_regwrite !== 1'b0) $display("FAIL invalid_regwrite: got %b expected 0", bus.e_regwrite); else pass_cnt++;
        total_cnt++; if (bus.e_waddr !== 5'd12) $display("FAIL invalid_waddr: got %h expected %h", bus.e_waddr, 5'd12); else pass_cnt++;
        total_cnt++; if (bus.A !== 32'h99) $display("FAIL invalid_a: got %h expected %h", bus.A, 32'h99); else pass_cnt++;
    endtask

    task automatic test_flush_vs_hold();
        clear_inputs();
        drive_instr(32'h3, 32'h4, 32'h5, ALU_SRA, 1'b1, 5'd2, 5'd3, 5'd9, 1'b1, 1'b1);
        step();
        drive_instr(32'hA, 32'hB, 32'hC, ALU_SUB, 1'b0, 5'd1, 5'd1, 5'd1, 1'b1, 1'b1);
        bus.e_hold  = 1'b1;
        bus.e_flush = 1'b1;
        step();
        total_cnt++; if (bus.e_valid !== 1'b1) $display("FAIL fh_valid: got %b expected 1", bus.e_valid); else pass_cnt++;
        total_cnt++; if (bus.ALUOp !== ALU_SRA) $display("FAIL fh_aluop: got %b expected %b", bus.ALUOp, ALU_SRA); else pass_cnt++;
        total_cnt++; if (bus.e_waddr !== 5'd9) $display("FAIL fh_waddr: got %h expected %h", bus.e_waddr, 5'd9); else pass_cnt++;
        total_cnt++; if (bus.B !== 32'h5) $display("FAIL fh_b: got %h expected %h", bus.B, 32'h5); else pass_cnt++;
        bus.e_hold = 1'b0;
        step();
        total_cnt++; if (bus.e_valid !== 1'b0) $display("FAIL flush_valid: got %b expected 0", bus.e_valid); else pass_cnt++;
        total_cnt++; if (bus.e_regwrite !== 1'b0) $display("FAIL flush_regwrite: got %b expected 0", bus.e_regwrite); else pass_cnt++;
        total_cnt++; if (bus.ALUOp !== 3'b000) $display("FAIL flush_aluop: got %b expected %b", bus.ALUOp, 3'b000); else pass_cnt++;
        total_cnt++; if (bus.e_waddr !== 5'd0) $display("FAIL flush_waddr: got %h expected %h", bus.e_waddr, 5'd0); else pass_cnt++;
        total_cnt++; if (bus.A !== 32'h0) $display("FAIL flush_a: got %h expected %h", bus.A, 32'h0); else pass_cnt++;
        total_cnt++; if (bus.B !== 32'h0) $display("FAIL flush_b: got %h expected %h", bus.B, 32'h0); else pass_cnt++;
        bus.e_flush = 1'b0;
    endtask

    task automatic test_passthrough();
        logic [2:0] ops [2];
        ops[0] = 3'b110;
        ops[1] = 3'b111;
        clear_inputs();
        for (int i = 0; i < 2; i++) begin
            drive_instr(32'h1, 32'h2, 32'h3, ops[i], 1'b0, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1);
            step();
            total_cnt++; if (bus.ALUOp !== ops[i]) $display("FAIL passthru_op%0d: got %b expected %b", i, bus.ALUOp, ops[i]); else pass_cnt++;
        end
    endtask

    task automatic test_async_reset();
        clear_inputs();
        drive_instr(32'h12, 32'h34, 32'h56, ALU_SRL, 1'b0, 5'd3, 5'd4, 5'd5, 1'b1, 1'b1);
        step();
        total_cnt++; if (bus.e_regwrite !== 1'b1) $display("FAIL ar_pre_regwrite: got %b expected 1", bus.e_regwrite); else pass_cnt++;
        bus.e_hold = 1'b1;
        #2 reset = 1'b0;
        #1;
        total_cnt++; if (bus.e_valid !== 1'b0) $display("FAIL ar_valid: got %b expected 0", bus.e_valid); else pass_cnt++;
        total_cnt++; if (bus.e_regwrite !== 1'b0) $display("FAIL ar_regwrite: got %b expected 0", bus.e_regwrite); else pass_cnt++;
        total_cnt++; if (bus.ALUOp !== 3'b000) $display("FAIL ar_aluop: got %b expected %b", bus.ALUOp, 3'b000); else pass_cnt++;
        total_cnt++; if (bus.A !== 32'h0) $display("FAIL ar_a: got %h expected %h", bus.A, 32'h0); else pass_cnt++;
        // Still holding after release: the discarded instruction must not return.
        step();
        #2 reset = 1'b1;
        step();
        total_cnt++; if (bus.e_valid !== 1'b0) $display("FAIL ar_hold_valid: got %b expected 0", bus.e_valid); else pass_cnt++;
        total_cnt++; if (bus.e_waddr !== 5'd0) $display("FAIL ar_hold_waddr: got %h expected %h", bus.e_waddr, 5'd0); else pass_cnt++;
        bus.e_hold = 1'b0;
        step();
        total_cnt++; if (bus.e_valid !== 1'b1) $display("FAIL ar_reload_valid: got %b expected 1", bus.e_valid); else pass_cnt++;
        total_cnt++; if (bus.A !== 32'h12) $display("FAIL ar_reload_a: got %h expected %h", bus.A, 32'h12); else pass_cnt++;
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        test_reset();
        test_load();
        test_priority();
        test_zero_reg();
        test_hold_refresh();
        test_flush_vs_hold();
        test_passthrough();
        test_async_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
